// File: rtl/diff_freq_serial_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : diff_freq_pkg
//  Description : Shared constants, control-byte layout and the channel state
//                type for the multi-channel dual-frequency pattern generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package diff_freq_pkg;

  // Control byte layout (last byte of every pack)
  localparam int c_START_BIT  = 7;
  localparam int c_REPEAT_BIT = 6;
  localparam int c_CH_MSB     = 5;
  localparam int c_CH_LSB     = 0;
  localparam int c_CH_W       = c_CH_MSB - c_CH_LSB + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ch_state_t;

  // Bytes per pack: output pattern, frequency pattern, control byte
  function automatic int pack_num(input int data_bit);
    return (2 * data_bit) / 8 + 1;
  endfunction

  localparam int c_PACK_NUM = pack_num(32);

endpackage
`default_nettype wire

// File: rtl/diff_freq_serial_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : diff_freq_serial_multi_if
//  Description : Byte stream from the UART receiver into the generator.
//                i_data          - received byte
//                i_rx_done_tick  - one-cycle strobe, i_data valid this cycle
//                master: UART receiver side, slave: pattern generator side
//  Revision    : 1.0 - initial release
// ============================================================================
interface diff_freq_serial_multi_if;
  logic [7:0] i_data;
  logic       i_rx_done_tick;

  modport master (output i_data, output i_rx_done_tick);
  modport slave  (input  i_data, input  i_rx_done_tick);
endinterface
`default_nettype wire

// File: rtl/diff_freq_serial_multi_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : freq_bit_serializer
//  Description : One output channel. Holds a shadow frame, the active frame,
//                the IDLE/SHIFT FSM, the per-bit divisor counter and the bit
//                index. Each bit lasts FAST_DIV clocks when its freq bit is 1,
//                otherwise SLOW_DIV clocks, LSB first.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_wr            - valid pack addressed to this channel
//                i_start         - START bit of the pack being written
//                i_pattern/i_freq/i_repeat - pack contents
//                o_serial_out    - pattern output (0 when idle)
//                o_bit_tick      - last clock of each bit
//                o_done_tick     - last clock of each frame
//                o_busy          - channel in SHIFT
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_bit_serializer
  import diff_freq_pkg::*;
#(
  parameter int DATA_BIT = 32,
  parameter int FAST_DIV = 10,
  parameter int SLOW_DIV = 20
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                i_wr,
  input  wire logic                i_start,
  input  wire logic [DATA_BIT-1:0] i_pattern,
  input  wire logic [DATA_BIT-1:0] i_freq,
  input  wire logic                i_repeat,
  output logic                     o_serial_out,
  output logic                     o_bit_tick,
  output logic                     o_done_tick,
  output logic                     o_busy
);

  localparam int c_MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
  localparam int c_CNT_W   = $clog2(c_MAX_DIV);
  localparam int c_IDX_W   = $clog2(DATA_BIT);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BIT - 1);

  ch_state_t             r_state;
  ch_state_t             w_state_nx;
  logic [DATA_BIT-1:0]   r_sh_pat;
  logic [DATA_BIT-1:0]   r_sh_freq;
  logic                  r_sh_repeat;
  logic                  r_shadow_valid;
  logic [DATA_BIT-1:0]   r_act_pat;
  logic [DATA_BIT-1:0]   r_act_freq;
  logic                  r_act_repeat;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_idx;

  logic [c_CNT_W-1:0]    w_div_last;
  logic                  w_bit_tick;
  logic                  w_done;
  logic                  w_load_wr;
  logic                  w_load_sh;
  logic                  w_wr_shadow;

  assign w_div_last = r_act_freq[r_idx] ? c_CNT_W'(FAST_DIV - 1) : c_CNT_W'(SLOW_DIV - 1);
  assign w_bit_tick = (r_state == ST_SHIFT) && (r_cnt == w_div_last);
  assign w_done     = w_bit_tick && (r_idx == c_LAST_IDX);

  // A pack launched while idle goes straight into the active registers so
  // bit 0 appears two clocks after the control byte; the shadow is only used
  // when the frame has to wait (armed, or channel currently shifting).
  // A pack written on the frame's final clock also bypasses the shadow; it is
  // newer than any pending shadow, so the shadow is dropped.
  always_comb begin
    w_state_nx  = r_state;
    w_load_wr   = 1'b0;
    w_load_sh   = 1'b0;
    w_wr_shadow = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_wr && i_start) begin
          w_load_wr  = 1'b1;
          w_state_nx = ST_SHIFT;
        end else if (i_wr) begin
          w_wr_shadow = 1'b1;
        end else if (i_start && r_shadow_valid) begin
          w_load_sh  = 1'b1;
          w_state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_done) begin
          if (i_wr) begin
            w_load_wr = 1'b1;
          end else if (r_shadow_valid) begin
            w_load_sh = 1'b1;
          end else if (!r_act_repeat) begin
            w_state_nx = ST_IDLE;
          end
        end else if (i_wr) begin
          w_wr_shadow = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_pat       <= '0;
      r_sh_freq      <= '0;
      r_sh_repeat    <= 1'b0;
      r_shadow_valid <= 1'b0;
      r_act_pat      <= '0;
      r_act_freq     <= '0;
      r_act_repeat   <= 1'b0;
      r_cnt          <= '0;
      r_idx          <= '0;
    end else begin
      if (w_wr_shadow) begin
        r_sh_pat       <= i_pattern;
        r_sh_freq      <= i_freq;
        r_sh_repeat    <= i_repeat;
        r_shadow_valid <= 1'b1;
      end

      if (w_load_wr) begin
        r_act_pat      <= i_pattern;
        r_act_freq     <= i_freq;
        r_act_repeat   <= i_repeat;
        r_shadow_valid <= 1'b0;
      end else if (w_load_sh) begin
        r_act_pat      <= r_sh_pat;
        r_act_freq     <= r_sh_freq;
        r_act_repeat   <= r_sh_repeat;
        r_shadow_valid <= 1'b0;
      end

      // Repeat and return-to-idle both fall out of the index wrapping to 0
      if (w_load_wr || w_load_sh) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_bit_tick) begin
          r_cnt <= '0;
          r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end
    end
  end

  assign o_busy       = (r_state == ST_SHIFT);
  assign o_serial_out = o_busy & r_act_pat[r_idx];
  assign o_bit_tick   = w_bit_tick;
  assign o_done_tick  = w_done;

endmodule
`default_nettype wire

// File: rtl/diff_freq_serial_multi.sv
`default_nettype none
// ============================================================================
//  Module      : diff_freq_serial_multi
//  Description : Multi-channel dual-frequency serial pattern generator.
//                Assembles UART bytes into packs (pattern, freq, control),
//                resynchronises on inter-byte timeout, decodes the channel
//                index and drives CH_NUM freq_bit_serializer channels.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                rx_if         - UART byte stream (slave)
//                o_serial_out  - per-channel pattern output
//                o_bit_tick    - per-channel last clock of each bit
//                o_done_tick   - per-channel last clock of each frame
//                o_busy        - per-channel SHIFT indicator
//                o_pack_err    - pulse when a pack addresses a missing channel
//  Revision    : 1.0 - initial release
// ============================================================================
module diff_freq_serial_multi
  import diff_freq_pkg::*;
#(
  parameter int CH_NUM   = 16,
  parameter int DATA_BIT = 32,
  parameter int FAST_DIV = 10,
  parameter int SLOW_DIV = 20,
  parameter int TIMEOUT  = 100_000
) (
  input  wire logic               clk,
  input  wire logic               rst,
  diff_freq_serial_multi_if.slave rx_if,
  output logic [CH_NUM-1:0]       o_serial_out,
  output logic [CH_NUM-1:0]       o_bit_tick,
  output logic [CH_NUM-1:0]       o_done_tick,
  output logic [CH_NUM-1:0]       o_busy,
  output logic                    o_pack_err
);

  localparam int c_PACK   = pack_num(DATA_BIT);
  localparam int c_BUF_W  = (c_PACK - 1) * 8;
  localparam int c_BCNT_W = $clog2(c_PACK);
  localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

  logic [c_BCNT_W-1:0] r_byte_cnt;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [c_BUF_W-1:0]  r_buf;
  logic                r_wr_en;
  logic [c_CH_W-1:0]   r_wr_ch;
  logic                r_wr_start;
  logic                r_wr_repeat;
  logic [DATA_BIT-1:0] r_wr_pat;
  logic [DATA_BIT-1:0] r_wr_freq;
  logic                r_pack_err;

  logic                w_timeout;
  logic [c_BCNT_W-1:0] w_byte_idx;
  logic                w_last_byte;
  logic [c_CH_W-1:0]   w_ch;
  logic                w_ch_ok;
  logic                w_start_all;

  // The idle counter saturates at TIMEOUT; a byte arriving in that cycle is
  // treated as byte 0 of a fresh pack.
  assign w_timeout   = (r_idle_cnt == c_IDLE_W'(TIMEOUT));
  assign w_byte_idx  = w_timeout ? '0 : r_byte_cnt;
  assign w_last_byte = (w_byte_idx == c_BCNT_W'(c_PACK - 1));
  assign w_ch        = rx_if.i_data[c_CH_MSB:c_CH_LSB];
  assign w_ch_ok     = ({1'b0, w_ch} < 7'(CH_NUM));
  assign w_start_all = r_wr_en & r_wr_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt  <= '0;
      r_idle_cnt  <= '0;
      r_buf       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_ch     <= '0;
      r_wr_start  <= 1'b0;
      r_wr_repeat <= 1'b0;
      r_wr_pat    <= '0;
      r_wr_freq   <= '0;
      r_pack_err  <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_pack_err <= 1'b0;
      if (rx_if.i_rx_done_tick) begin
        r_idle_cnt <= '0;
        if (w_last_byte) begin
          r_byte_cnt <= '0;
          if (w_ch_ok) begin
            r_wr_en     <= 1'b1;
            r_wr_ch     <= w_ch;
            r_wr_start  <= rx_if.i_data[c_START_BIT];
            r_wr_repeat <= rx_if.i_data[c_REPEAT_BIT];
            r_wr_pat    <= r_buf[DATA_BIT-1:0];
            r_wr_freq   <= r_buf[2*DATA_BIT-1:DATA_BIT];
          end else begin
            r_pack_err <= 1'b1;
          end
        end else begin
          r_byte_cnt <= w_byte_idx + c_BCNT_W'(1);
          for (int b = 0; b < c_PACK - 1; b++) begin
            if (w_byte_idx == c_BCNT_W'(b)) begin
              r_buf[b*8 +: 8] <= rx_if.i_data;
            end
          end
        end
      end else if (w_timeout) begin
        r_byte_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
      end
    end
  end

  assign o_pack_err = r_pack_err;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    logic w_wr;
    assign w_wr = r_wr_en && (r_wr_ch == c_CH_W'(g));

    freq_bit_serializer #(
      .DATA_BIT (DATA_BIT),
      .FAST_DIV (FAST_DIV),
      .SLOW_DIV (SLOW_DIV)
    ) u_ser (
      .clk          (clk),
      .rst          (rst),
      .i_wr         (w_wr),
      .i_start      (w_start_all),
      .i_pattern    (r_wr_pat),
      .i_freq       (r_wr_freq),
      .i_repeat     (r_wr_repeat),
      .o_serial_out (o_serial_out[g]),
      .o_bit_tick   (o_bit_tick[g]),
      .o_done_tick  (o_done_tick[g]),
      .o_busy       (o_busy[g])
    );
  end

endmodule
`default_nettype wire

// File: doc/diff_freq_serial_multi.md
# diff_freq_serial_multi

Multi-channel successor to the dual-frequency serial pattern generator. It assembles UART bytes into packs and stores each pack in a per-channel double buffer. Each of CH_NUM channels then shifts out a DATA_BIT-bit pattern, with each bit lasting either FAST_DIV or SLOW_DIV clocks. It adds per-channel addressing, repeat mode, synchronous multi-channel start, gapless frame reload and pack-timeout resynchronisation. It sits between the UART receiver and the FPGA pattern pins, on the PLL clock domain.

## Interface
- CH_NUM, 16: channel count, 1..64
- DATA_BIT, 32: pattern bits per frame, multiple of 8, ≥ 8
- FAST_DIV, 10: clocks per bit when freq bit = 1, ≥ 2
- SLOW_DIV, 20: clocks per bit when freq bit = 0, ≥ 2
- TIMEOUT, 100_000: idle clocks between bytes before the pack assembler resyncs, ≥ 1
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- i_data  in  8  received UART byte
- i_rx_done_tick  in  1  one-cycle strobe; i_data valid this cycle
- o_serial_out  out  CH_NUM  per-channel serial output
- o_bit_tick  out  CH_NUM  pulse on last clock of each bit
- o_done_tick  out  CH_NUM  pulse on last clock of each frame
- o_busy  out  CH_NUM  channel in SHIFT
- o_pack_err  out  1  pulse when a pack is discarded

## Operation
- Pack = PACK_NUM = 2·DATA_BIT/8 + 1 bytes. Byte order:
  - output pattern, LSB byte first
  - frequency pattern, LSB byte first
  - control byte: [7] START, [6] REPEAT, [5:0] channel index
- Byte counter wraps to 0 after the control byte.
- Idle counter restarts on every i_rx_done_tick. When it reaches TIMEOUT, the byte counter clears and the partial pack is dropped silently.
- If the strobe arrives in the timeout cycle, that byte is byte 0 of a new pack.
- Channel index ≥ CH_NUM: the pack is discarded and o_pack_err pulses one cycle.
- Valid pack: writes the channel's shadow {pattern, freq, REPEAT} and sets shadow_valid. This overwrites any unconsumed shadow.
- Channel FSM has two states, IDLE and SHIFT.
  - IDLE → SHIFT when shadow_valid and either START of the current pack is 1, or the current pack addresses this channel with START=1.
  - START=1 launches every idle channel holding a valid shadow in the same cycle. START=0 arms only.
  - On entry to SHIFT, the active registers take the shadow and shadow_valid clears.
- SHIFT:
  - Bits are sent LSB first. Bit i is held FAST_DIV clocks if freq[i]=1, otherwise SLOW_DIV clocks.
  - On the last clock of bit DATA_BIT-1, o_done_tick pulses. The next state is chosen in this priority order:
    - shadow_valid: load the shadow, stay in SHIFT (gapless, no idle cycle)
    - active REPEAT=1: reload the same active pattern
    - otherwise: IDLE
- A REPEAT=0 pack sent to a repeating channel ends the repetition after one frame of the new pattern.
- IDLE output is 0, and o_bit_tick / o_done_tick are 0.

## Timing
- Reset value: every output 0. All shadows are invalid, the byte counter and idle counter are 0, and all channels are IDLE.
- Control byte strobe at cycle T:
  - shadow written at T+1
  - launched channel drives bit 0 from T+2
- Bit 0 stays on o_serial_out for exactly its divisor length. A frame lasts the sum of its per-bit divisors, with no extra cycles.
- Gapless reload: bit 0 of the next frame appears on the clock immediately after o_done_tick.
- o_bit_tick and o_done_tick coincide on the final bit.
- rst mid-frame: at the next edge, outputs are 0 and all state is cleared. No done tick is emitted.
- Bit-cycle counter width: $clog2(max(FAST_DIV,SLOW_DIV)). Bit index width: $clog2(DATA_BIT).

## Structure
- Package diff_freq_pkg holds:
  - PACK_NUM
  - control-byte bit positions (START=7, REPEAT=6, channel field 5:0)
  - channel state enum {IDLE, SHIFT}
- Sub-module freq_bit_serializer holds one channel: shadow, FSM, divisor counter and bit index. It is instantiated CH_NUM times via generate.
- The top level holds the pack assembler, the timeout counter and the channel decode.

## Test plan
- Ch 3, pattern 0x0000_00A5, freq 0xFFFF_FFFF, control 0x83: o_serial_out[3] shows 1,0,1,0,0,1,0,1 then zeros; each bit lasts 10 clocks; o_done_tick[3] pulses at clock 320 after launch.
- Ch 0, freq 0x0000_0000, control 0xC0: frame length is 640 clocks and repeats. A second pack (control 0x80, new pattern) takes effect at the frame boundary with zero gap, runs one frame, then o_busy[0] falls.
- Arm ch 1 (0x01) and ch 2 (0x02), then send ch 5 with 0x85: channels 1, 2 and 5 start on the same clock.
- Control 0x50 with CH_NUM=16: o_pack_err pulses once and no channel changes.
- Send 4 bytes, idle TIMEOUT+1 clocks, then send a full pack to ch 4: ch 4 receives the full pack correctly.
- Assert rst at bit 10 of an active frame: all outputs 0 on the next clock, and a following pack behaves as after power-up.
